// File: rtl/sample_tick_gen.sv
// Sample-rate tick generator with a single-outstanding sample fetch FSM.
// Optional tick counter: define SAMPLE_TICK_COUNT_EN to build tick_count.
module sample_tick_gen #(
  parameter int unsigned MIN_DIVISOR = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] clk_divisor,
  input  logic        enable,
  output logic        tick,
  output logic        rd_req,
  input  logic        rd_ack,
  input  logic [7:0]  rd_data,
  output logic [7:0]  sample_out,
  output logic        sample_valid,
  output logic        overrun,
  input  logic        clr_overrun,
  output logic [31:0] tick_count
);

  typedef enum logic {ST_IDLE, ST_WAIT} state_e;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        tick_q, tick_d;
  logic [7:0]  sample_out_q, sample_out_d;
  logic        sample_valid_q, sample_valid_d;
  logic        overrun_q, overrun_d;
  logic        overrun_set;
  logic [31:0] eff_div;
  logic        wrap;

  // >= compare lets a lowered divisor wrap at once instead of running to 2^32
  always_comb begin
    eff_div = (clk_divisor < 32'(MIN_DIVISOR)) ? 32'(MIN_DIVISOR) : clk_divisor;
    wrap    = enable && (cnt_q >= eff_div - 32'd1);
    cnt_d   = cnt_q;
    if (enable) cnt_d = wrap ? 32'd0 : cnt_q + 32'd1;
    tick_d  = wrap;
  end

  // Pausing masks a tick already registered so nothing is launched while paused
  assign tick = tick_q && enable;

  always_comb begin
    state_d        = state_q;
    sample_out_d   = sample_out_q;
    sample_valid_d = 1'b0;
    overrun_set    = 1'b0;
    rd_req         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          state_d = ST_WAIT;
          rd_req  = 1'b1;
        end
      end
      ST_WAIT: begin
        rd_req = 1'b1;
        if (rd_ack) begin
          sample_out_d   = rd_data;
          sample_valid_d = 1'b1;
          state_d        = tick ? ST_WAIT : ST_IDLE;
        end else if (tick) begin
          overrun_set = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    overrun_d = overrun_set | (overrun_q & ~clr_overrun);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      tick_q         <= 1'b0;
      sample_out_q   <= '0;
      sample_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      tick_q         <= tick_d;
      sample_out_q   <= sample_out_d;
      sample_valid_q <= sample_valid_d;
      overrun_q      <= overrun_d;
    end
  end

  assign sample_out   = sample_out_q;
  assign sample_valid = sample_valid_q;
  assign overrun      = overrun_q;

`ifdef SAMPLE_TICK_COUNT_EN
  logic [31:0] tick_count_q, tick_count_d;

  always_comb begin
    tick_count_d = tick_count_q;
    if (tick) tick_count_d = tick_count_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) tick_count_q <= '0;
    else       tick_count_q <= tick_count_d;
  end

  assign tick_count = tick_count_q;
`else
  assign tick_count = '0;
`endif

endmodule

// File: tb/tb_sample_tick_gen.sv
// Scoreboard bench for sample_tick_gen: stimulus queues expected tick and
// sample_valid events (by cycle number), a monitor pops and compares them.
module tb_sample_tick_gen;

  typedef struct {
    int         cyc;
    logic [7:0] data;
  } sv_exp_t;

`ifdef SAMPLE_TICK_COUNT_EN
  localparam bit TC_EN = 1'b1;
`else
  localparam bit TC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] clk_divisor = 32'd16;
  logic        enable = 1'b1;
  logic        rd_ack = 1'b0;
  logic [7:0]  rd_data = 8'hEE;
  logic        clr_overrun = 1'b0;
  logic        tick, rd_req, sample_valid, overrun;
  logic [7:0]  sample_out;
  logic [31:0] tick_count;

  sample_tick_gen #(.MIN_DIVISOR(16)) dut (
    .clk(clk), .reset(reset), .clk_divisor(clk_divisor), .enable(enable),
    .tick(tick), .rd_req(rd_req), .rd_ack(rd_ack), .rd_data(rd_data),
    .sample_out(sample_out), .sample_valid(sample_valid), .overrun(overrun),
    .clr_overrun(clr_overrun), .tick_count(tick_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int      checks = 0;
  int      errors = 0;
  bit      mon_en = 1'b0;
  int      ack_lat = 0;
  int      exp_tick[$];
  sv_exp_t exp_sv[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare every observed event against the head of its queue
  int      m_tick;
  sv_exp_t m_sv;
  initial forever begin
    @(negedge clk); #1;
    if (mon_en) begin
      if (tick) begin
        if (exp_tick.size() == 0) chk("tick_unexpected", 32'(cyc), 32'hFFFF_FFFF);
        else begin
          m_tick = exp_tick.pop_front();
          chk("tick_cycle", 32'(cyc), 32'(m_tick));
        end
      end
      if (sample_valid) begin
        if (exp_sv.size() == 0) chk("sv_unexpected", 32'(cyc), 32'hFFFF_FFFF);
        else begin
          m_sv = exp_sv.pop_front();
          chk("sv_cycle", 32'(cyc), 32'(m_sv.cyc));
          chk("sv_data", 32'(sample_out), 32'(m_sv.data));
        end
      end
    end
  end

  // Reader model: acks ack_lat cycles after rd_req rises; data tagged by cycle
  int resp_cd = 0;
  bit resp_prev = 1'b0;
  initial forever begin
    @(negedge clk);
    if (resp_cd > 0) begin
      resp_cd--;
      if (resp_cd == 0) begin
        rd_ack  = 1'b1;
        rd_data = 8'(cyc) ^ 8'hA5;
      end
    end else begin
      rd_ack  = 1'b0;
      rd_data = 8'hEE;
      if (ack_lat > 0 && rd_req && !resp_prev) resp_cd = ack_lat;
    end
    resp_prev = rd_req;
  end

  task automatic wait_to(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic start(input logic [31:0] div, output int base);
    @(negedge clk);
    mon_en = 1'b0; reset = 1'b1; enable = 1'b0; clr_overrun = 1'b0;
    repeat (2) @(negedge clk);
    clk_divisor = div; enable = 1'b1; reset = 1'b0; mon_en = 1'b1;
    base = cyc;
  endtask

  task automatic drain(input string name);
    chk({name, "_ticks_left"}, 32'(exp_tick.size()), 32'd0);
    chk({name, "_sv_left"}, 32'(exp_sv.size()), 32'd0);
  endtask

  task automatic push_sv(input int c);
    sv_exp_t e;
    e.cyc  = c;
    e.data = 8'(c - 1) ^ 8'hA5;
    exp_sv.push_back(e);
  endtask

  initial begin
    int b;
    // reset state, with enable high to show reset wins
    repeat (3) @(negedge clk);
    #1;
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_rd_req", 32'(rd_req), 32'd0);
    chk("rst_sample_out", 32'(sample_out), 32'd0);
    chk("rst_sample_valid", 32'(sample_valid), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_tick_count", tick_count, 32'd0);

    // steady rate, ack 3 cycles after request
    ack_lat = 3;
    start(32'd6944, b);
    for (int k = 1; k <= 3; k++) begin
      exp_tick.push_back(b + 6944 * k);
      push_sv(b + 6944 * k + 4);
    end
    wait_to(b + 3 * 6944 + 6); #1;
    drain("steady");
    chk("steady_overrun", 32'(overrun), 32'd0);
    chk("steady_tick_count", tick_count, TC_EN ? 32'd3 : 32'd0);

    // clamping of small divisors
    ack_lat = 0;
    start(32'd4, b);
    for (int k = 1; k <= 5; k++) exp_tick.push_back(b + 16 * k);
    wait_to(b + 81); #1;
    chk("clamp4_tick_count", tick_count, TC_EN ? 32'd5 : 32'd0);
    drain("clamp4");
    start(32'd0, b);
    exp_tick.push_back(b + 16);
    exp_tick.push_back(b + 32);
    wait_to(b + 33); #1;
    drain("clamp0");

    // divisor drop mid-count at cnt=500
    start(32'd1000, b);
    wait_to(b + 500);
    clk_divisor = 32'd100;
    exp_tick.push_back(b + 501);
    exp_tick.push_back(b + 601);
    exp_tick.push_back(b + 701);
    wait_to(b + 702); #1;
    drain("drop");

    // overrun: no ack ever
    start(32'd16, b);
    exp_tick.push_back(b + 16);
    exp_tick.push_back(b + 32);
    exp_tick.push_back(b + 48);
    wait_to(b + 16); #1;
    chk("ovr_first_tick_overrun", 32'(overrun), 32'd0);
    chk("ovr_rd_req_first", 32'(rd_req), 32'd1);
    wait_to(b + 31); #1;
    chk("ovr_before_second", 32'(overrun), 32'd0);
    chk("ovr_rd_req_held", 32'(rd_req), 32'd1);
    wait_to(b + 33); #1;
    chk("ovr_set", 32'(overrun), 32'd1);
    clr_overrun = 1'b1;
    wait_to(b + 34); clr_overrun = 1'b0; #1;
    chk("ovr_cleared", 32'(overrun), 32'd0);
    wait_to(b + 48); clr_overrun = 1'b1;
    wait_to(b + 49); clr_overrun = 1'b0; #1;
    chk("ovr_set_beats_clr", 32'(overrun), 32'd1);
    drain("ovr");

    // pause for 50 cycles with a fetch pending, then reset during a fetch
    ack_lat = 3;
    start(32'd16, b);
    exp_tick.push_back(b + 16);
    exp_tick.push_back(b + 82);
    exp_tick.push_back(b + 98);
    push_sv(b + 20);
    push_sv(b + 86);
    wait_to(b + 17); enable = 1'b0;
    wait_to(b + 67); enable = 1'b1;
    wait_to(b + 99); reset = 1'b1;
    wait_to(b + 100); reset = 1'b0; enable = 1'b0; #1;
    chk("rstwait_rd_req", 32'(rd_req), 32'd0);
    chk("rstwait_sample_out", 32'(sample_out), 32'd0);
    chk("rstwait_overrun", 32'(overrun), 32'd0);
    wait_to(b + 104); #1;
    chk("late_ack_sample_out", 32'(sample_out), 32'd0);
    chk("late_ack_rd_req", 32'(rd_req), 32'd0);
    drain("pause");

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sample_tick_gen.md
SAMPLE_TICK_GEN -- requirements
Module: sample_tick_gen

Interface
REQ-001 SHALL have parameter MIN_DIVISOR, default 16: smallest effective clock divisor; lower requested divisors are clamped up to it.
REQ-002 SHALL have port clk, input, 1 bit: system clock, 50 MHz.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port clk_divisor, input, 32 bits: requested sample period in clk cycles, from the speed-control block.
REQ-005 SHALL have port enable, input, 1 bit: 1 = run; 0 = pause playback.
REQ-006 SHALL have port tick, output, 1 bit: one-cycle sample strobe.
REQ-007 SHALL have port rd_req, output, 1 bit: sample fetch request to the flash/memory reader.
REQ-008 SHALL have port rd_ack, input, 1 bit: one-cycle acknowledge from the reader; rd_data is valid in the same cycle.
REQ-009 SHALL have port rd_data, input, 8 bits: fetched audio sample.
REQ-010 SHALL have port sample_out, output, 8 bits: last fetched sample, held until replaced.
REQ-011 SHALL have port sample_valid, output, 1 bit: one-cycle pulse when sample_out updates.
REQ-012 SHALL have port overrun, output, 1 bit: sticky flag; a tick arrived while a fetch was outstanding.
REQ-013 SHALL have port clr_overrun, input, 1 bit: clears overrun.
REQ-014 SHALL have port tick_count, output, 32 bits: total ticks issued (see Configuration).

Function
REQ-015 SHALL compute the effective divisor each cycle as follows: eff_div = max(clk_divisor, MIN_DIVISOR), unsigned 32-bit compare.
REQ-016 SHALL, with enable=1, set the 32-bit counter cnt to 0 when cnt >= eff_div-1, and otherwise increment it by 1.
REQ-017 SHALL register tick high in the cycle after the cycle in which cnt wraps; the tick period SHALL equal eff_div cycles when the divisor is steady.
REQ-018 SHALL apply a divisor change mid-count immediately: if cnt is already >= new eff_div-1, it wraps on the next enabled cycle, with no long wrap through 2^32.
REQ-019 SHALL, with enable=0, hold cnt and force tick=0; an outstanding fetch SHALL still complete.
REQ-020 SHALL implement the fetch FSM with two states, IDLE and WAIT.
  - IDLE: on tick, go to WAIT with rd_req=1 in that same cycle.
  - WAIT: hold rd_req=1 until rd_ack. On rd_ack, latch rd_data into sample_out, pulse sample_valid in the next cycle, and return to IDLE.
REQ-021 SHALL, when a tick occurs in WAIT without rd_ack, set overrun=1, stay in WAIT, and drop the tick (not queue it).
REQ-022 SHALL, when tick and rd_ack coincide in WAIT, complete the current fetch and immediately start a new one (stay in WAIT, rd_req stays 1), with overrun unchanged.
REQ-023 SHALL ignore rd_ack in IDLE.
REQ-024 SHALL give set priority on overrun: if set and clr_overrun coincide, overrun=1.

Reset
REQ-025 SHALL, on reset, set cnt=0, tick=0, rd_req=0, FSM=IDLE, sample_out=8'h00, sample_valid=0, overrun=0, and tick_count=0.
REQ-026 SHALL let reset mid-fetch abandon the fetch, deasserting rd_req next cycle; a later rd_ack SHALL be ignored.
REQ-027 SHALL give reset priority over every other input.

Configuration
REQ-028 SHALL use macro SAMPLE_TICK_COUNT_EN.
  - Defined: tick_count increments by 1 on every tick and wraps from 32'hFFFFFFFF to 0.
  - Undefined: tick_count is constant 0 and no counter logic is synthesized.

Verification
REQ-029 SHALL cover steady rate: clk_divisor=6944, enable=1, rd_ack 3 cycles after rd_req -> tick every 6944 cycles, sample_valid 4 cycles after each tick, overrun=0.
REQ-030 SHALL cover clamping: clk_divisor=4 -> tick period 16 cycles; clk_divisor=0 -> period 16.
REQ-031 SHALL cover divisor drop mid-count: divisor 1000, at cnt=500 change to 100 -> cnt wraps next cycle and tick follows; subsequent period 100.
REQ-032 SHALL cover overrun: divisor 16, rd_ack never asserted -> rd_req held high; overrun=1 at the second tick; clr_overrun -> 0; coincident set+clr -> 1.
REQ-033 SHALL cover pause and reset: enable=0 for 50 cycles -> no ticks, cnt frozen, pending ack still yields sample_valid; reset during WAIT -> rd_req=0, sample_out=0, late rd_ack ignored.
REQ-034 SHALL cover the macro: with SAMPLE_TICK_COUNT_EN, after 5 ticks tick_count=5; without it, tick_count=0 throughout.
